// File: rtl/uart_prog_loader_if.sv
// Write and status bus from the UART program loader towards the program/data memories and CPU top.
interface uart_prog_loader_if #(
    parameter int ADDR_W = 14
);
    logic            wen_o;
    logic [ADDR_W:0] adr_o;
    logic [31:0]     dat_o;
    logic            busy_o;
    logic            done_o;
    logic [1:0]      err_o;

    modport master (output wen_o, adr_o, dat_o, busy_o, done_o, err_o);
    modport slave  (input  wen_o, adr_o, dat_o, busy_o, done_o, err_o);
endinterface

// File: rtl/uart_prog_loader.sv
// UART program loader: receives CMD/LEN/DATA/CSUM frames and issues 32-bit word writes
// to instruction (adr MSB 0) or data (adr MSB 1) memory, with sticky error reporting.
module uart_prog_loader #(
    parameter int CLK_HZ = 10_000_000,
    parameter int BAUD   = 128_000,
    parameter int ADDR_W = 14
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               enable,
    input  logic               rx,
    uart_prog_loader_if.master bus
);
    localparam int DIV_RAW = CLK_HZ / BAUD;
    localparam int DIV     = (DIV_RAW < 4) ? 4 : DIV_RAW;
    localparam int CNT_W   = $clog2(DIV);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam logic [31:0]      LEN_MAX   = 32'd1 << ADDR_W;

    localparam logic [7:0] CMD_IMEM = 8'hA5;
    localparam logic [7:0] CMD_DMEM = 8'h5A;
    localparam logic [7:0] CMD_END  = 8'hFF;
    localparam logic [1:0] ERR_FRAME = 2'd1;
    localparam logic [1:0] ERR_CSUM  = 2'd2;
    localparam logic [1:0] ERR_CMD   = 2'd3;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} state_e;

    rx_state_e        rx_state_q;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_byte_q;
    logic             byte_stb_q, frame_err_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_byte_q   <= '0;
            byte_stb_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            byte_stb_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_cnt_q    <= rx_cnt_q + 1'b1;
            case (rx_state_q)
                RX_IDLE: begin
                    rx_cnt_q <= '0;
                    if (rx_prev_q && !rx_sync_q) rx_state_q <= RX_START;
                end
                RX_START: if (rx_cnt_q == HALF_LAST) begin
                    // Line back high at mid-start means a glitch: drop it.
                    rx_cnt_q   <= '0;
                    rx_bit_q   <= '0;
                    rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_q  <= '0;
                    rx_byte_q <= {rx_sync_q, rx_byte_q[7:1]};
                    rx_bit_q  <= rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                end
                RX_STOP: if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_q    <= '0;
                    byte_stb_q  <= rx_sync_q;
                    frame_err_q <= !rx_sync_q;
                    rx_state_q  <= RX_IDLE;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    state_e          state_q, state_d;
    logic [1:0]      err_q, err_d;
    logic            sel_q;
    logic [7:0]      len_lo_q;
    logic [15:0]     words_left_q;
    logic [ADDR_W-1:0] idx_q;
    logic [1:0]      byte_cnt_q;
    logic [23:0]     word_q;
    logic [7:0]      csum_q;
    logic            wen_q;
    logic [ADDR_W:0] adr_q;
    logic [31:0]     dat_q;
    logic [15:0]     len_full;
    logic            in_frame;

    assign len_full = {rx_byte_q, len_lo_q};
    assign in_frame = state_q inside {S_CMD, S_LEN0, S_LEN1, S_DATA, S_CSUM};

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= S_IDLE;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // NOTE: defaults first so no path through the block leaves a signal unassigned (no latch).
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (enable) state_d = S_CMD;
            S_CMD: if (byte_stb_q) begin
                if (rx_byte_q == CMD_IMEM || rx_byte_q == CMD_DMEM) begin
                    state_d = S_LEN0;
                end else if (rx_byte_q == CMD_END) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ERR;
                    err_d   = ERR_CMD;
                end
            end
            S_LEN0: if (byte_stb_q) state_d = S_LEN1;
            S_LEN1: if (byte_stb_q) begin
                if (len_full == 16'd0) begin
                    state_d = S_CSUM;
                end else if ({16'd0, len_full} > LEN_MAX) begin
                    state_d = S_ERR;
                    err_d   = ERR_CMD;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DATA: if (byte_stb_q && byte_cnt_q == 2'd3 && words_left_q == 16'd1) state_d = S_CSUM;
            S_CSUM: if (byte_stb_q) begin
                if (rx_byte_q == csum_q) begin
                    state_d = S_CMD;
                end else begin
                    state_d = S_ERR;
                    err_d   = ERR_CSUM;
                end
            end
            default: ;
        endcase
        // Abort wins over a framing error; neither applies once DONE/ERR is reached.
        if (in_frame) begin
            if (frame_err_q) begin
                state_d = S_ERR;
                err_d   = ERR_FRAME;
            end
            if (!enable) begin
                state_d = S_IDLE;
                err_d   = err_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            sel_q        <= 1'b0;
            len_lo_q     <= '0;
            words_left_q <= '0;
            idx_q        <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            csum_q       <= '0;
            wen_q        <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
        end else begin
            wen_q <= 1'b0;
            if (state_d == S_IDLE) begin
                byte_cnt_q <= '0;
                word_q     <= '0;
            end else if (byte_stb_q) begin
                case (state_q)
                    S_CMD: begin
                        sel_q      <= (rx_byte_q == CMD_DMEM);
                        idx_q      <= '0;
                        csum_q     <= '0;
                        byte_cnt_q <= '0;
                    end
                    S_LEN0: len_lo_q <= rx_byte_q;
                    S_LEN1: words_left_q <= len_full;
                    S_DATA: begin
                        csum_q     <= csum_q ^ rx_byte_q;
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        word_q     <= {rx_byte_q, word_q[23:8]};
                        if (byte_cnt_q == 2'd3) begin
                            wen_q        <= 1'b1;
                            adr_q        <= {sel_q, idx_q};
                            dat_q        <= {rx_byte_q, word_q};
                            idx_q        <= idx_q + 1'b1;
                            words_left_q <= words_left_q - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.wen_o  = wen_q;
        bus.adr_o  = adr_q;
        bus.dat_o  = dat_q;
        bus.busy_o = state_q inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
        bus.done_o = (state_q == S_DONE);
        bus.err_o  = err_q;
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: serial frames in, expected writes scoreboarded and popped on wen_o.
module tb_uart_prog_loader;
    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int ADDR_W = 14;
    localparam int DIV    = 10;

    typedef struct packed {
        logic [ADDR_W:0] adr;
        logic [31:0]     dat;
    } wr_t;
    typedef logic [7:0] bq_t[$];

    logic clock = 1'b0;
    logic rst, enable, rx;
    int   tests_run = 0;
    int   tests_failed = 0;
    wr_t  sb_q[$];
    bq_t  tx;
    logic [7:0] csum;
    logic [31:0] words [3];

    uart_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    uart_prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .rst   (rst),
        .enable(enable),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest pending expected write.
    always @(negedge clock) begin
        if (bus.wen_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", 64'({bus.adr_o, bus.dat_o}), 64'hDEAD_0000_0000_0000);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check("write", 64'({bus.adr_o, bus.dat_o}), 64'(e));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx = 1'b0;
        idle(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(DIV);
        end
        rx = stop;
        idle(DIV);
        rx = 1'b1;
    endtask

    task automatic send_seq(input bq_t s);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        rx = 1'b1;
        idle(4);
        rst = 1'b0;
        idle(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        rx = 1'b1;
        idle(4);
        check("rst_wen",  bus.wen_o,  0);
        check("rst_adr",  bus.adr_o,  0);
        check("rst_dat",  bus.dat_o,  0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_done", bus.done_o, 0);
        check("rst_err",  bus.err_o,  0);
        rst = 1'b0;
        idle(2);

        // Single instruction word
        enable = 1'b1;
        idle(2);
        sb_q.push_back(wr_t'{adr: 15'h0000, dat: 32'h12345678});
        tx = {8'hA5, 8'h01, 8'h00};
        send_seq(tx);
        idle(3);
        check("t1_busy_in_frame", bus.busy_o, 1);
        tx = {8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        send_seq(tx);
        idle(20);
        check("t1_busy_after", bus.busy_o, 0);
        check("t1_err", bus.err_o, 0);
        check("t1_done", bus.done_o, 0);
        check("t1_pending", 64'(sb_q.size()), 0);

        // Three-word data-memory frame, then END
        do_reset();
        enable = 1'b1;
        idle(2);
        words[0] = 32'h11223344;
        words[1] = 32'hA5A50F0F;
        words[2] = 32'hDEADBEEF;
        csum = 8'h00;
        tx = {8'h5A, 8'h03, 8'h00};
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) begin
                tx.push_back(words[i][8*k +: 8]);
                csum = csum ^ words[i][8*k +: 8];
            end
            sb_q.push_back(wr_t'{adr: 15'h4000 + 15'(i), dat: words[i]});
        end
        tx.push_back(csum);
        tx.push_back(8'hFF);
        send_seq(tx);
        idle(20);
        check("t2_done", bus.done_o, 1);
        check("t2_err", bus.err_o, 0);
        check("t2_busy", bus.busy_o, 0);
        check("t2_pending", 64'(sb_q.size()), 0);
        tx = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        send_seq(tx);
        idle(20);
        check("t2_done_hold", bus.done_o, 1);
        check("t2_dat_hold", bus.dat_o, 32'hDEADBEEF);

        // Checksum corruption
        do_reset();
        enable = 1'b1;
        idle(2);
        sb_q.push_back(wr_t'{adr: 15'h0000, dat: 32'h12345678});
        tx = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
        send_seq(tx);
        idle(20);
        check("t3_err_csum", bus.err_o, 2);
        check("t3_pending", 64'(sb_q.size()), 0);
        tx = {8'hFF};
        send_seq(tx);
        idle(20);
        check("t3_no_done", bus.done_o, 0);
        check("t3_err_sticky", bus.err_o, 2);

        // Framing error inside DATA
        do_reset();
        enable = 1'b1;
        idle(2);
        tx = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56};
        send_seq(tx);
        send_byte(8'h34, 1'b0);
        idle(20);
        check("t4_err_frame", bus.err_o, 1);
        check("t4_busy", bus.busy_o, 0);
        tx = {8'h12, 8'h08};
        send_seq(tx);
        idle(20);
        check("t4_err_sticky", bus.err_o, 1);
        check("t4_wen_never", bus.dat_o, 0);

        // Glitch rejection, then max legal length accepted
        do_reset();
        enable = 1'b1;
        idle(2);
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(30);
        check("t5_glitch_err", bus.err_o, 0);
        check("t5_glitch_done", bus.done_o, 0);
        check("t5_glitch_busy", bus.busy_o, 0);
        tx = {8'hA5};
        send_seq(tx);
        idle(5);
        check("t5_cmd_after_glitch", bus.busy_o, 1);
        tx = {8'h00, 8'h40};
        send_seq(tx);
        idle(5);
        check("t5_len_max_busy", bus.busy_o, 1);
        check("t5_len_max_err", bus.err_o, 0);

        // Bad command
        do_reset();
        enable = 1'b1;
        idle(2);
        tx = {8'h33};
        send_seq(tx);
        idle(5);
        check("t5_bad_cmd", bus.err_o, 3);
        check("t5_bad_cmd_busy", bus.busy_o, 0);

        // Length one over the limit
        do_reset();
        enable = 1'b1;
        idle(2);
        tx = {8'hA5, 8'h01, 8'h40};
        send_seq(tx);
        idle(5);
        check("t5_bad_len", bus.err_o, 3);

        // Abort via enable, then a fresh frame
        do_reset();
        enable = 1'b1;
        idle(2);
        tx = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56};
        send_seq(tx);
        idle(5);
        enable = 1'b0;
        idle(2);
        check("t6_abort_busy", bus.busy_o, 0);
        check("t6_abort_err", bus.err_o, 0);
        enable = 1'b1;
        idle(2);
        sb_q.push_back(wr_t'{adr: 15'h0000, dat: 32'h12345678});
        tx = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        send_seq(tx);
        idle(20);
        check("t6_pending", 64'(sb_q.size()), 0);
        check("t6_err", bus.err_o, 0);

        // Reset mid-frame with a character in flight
        do_reset();
        enable = 1'b1;
        idle(2);
        sb_q.push_back(wr_t'{adr: 15'h0000, dat: 32'h12345678});
        tx = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08, 8'hA5, 8'h01};
        send_seq(tx);
        rx = 1'b0;
        idle(30);
        check("t7_pre_busy", bus.busy_o, 1);
        check("t7_pre_dat", bus.dat_o, 32'h12345678);
        check("t7_pending", 64'(sb_q.size()), 0);
        rst = 1'b1;
        @(posedge clock);
        #1;
        check("t7_rst_wen",  bus.wen_o,  0);
        check("t7_rst_adr",  bus.adr_o,  0);
        check("t7_rst_dat",  bus.dat_o,  0);
        check("t7_rst_busy", bus.busy_o, 0);
        check("t7_rst_done", bus.done_o, 0);
        check("t7_rst_err",  bus.err_o,  0);
        @(negedge clock);
        rst = 1'b0;
        rx = 1'b1;
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
